uart_tx_arbiter: RTL



---
 rtl/uart_link_pkg.sv | 17 +
 rtl/rr_priority_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uart_link_pkg.sv
// Shared types and helpers for the UART link arbitration and scheduling blocks.
package uart_link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA
    } arb_state_t;

    localparam logic [7:0] HEADER_BASE_DEFAULT = 8'hA0;

    // Header byte identifying the granted source; the caller truncates to its byte width.
    function automatic logic [31:0] header_byte(input logic [31:0] base, input logic [31:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority pick: first asserted request at or above ptr, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_priority_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     winner,
    output logic             found
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = PTR_W'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte streams, round-robin per packet, optional source header.
// Latency: one arbitration cycle in IDLE, then header and data pass straight through to tx.
// Backpressure: tx_ready feeds the granted req_ready combinationally; ena=0 freezes everything.
module uart_tx_arbiter
    import uart_link_pkg::*;
#(
    parameter int                    NUM_REQ     = 4,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    MAX_BURST   = 16,
    parameter int                    HEADER_EN   = 1,
    parameter logic [DATA_WIDTH-1:0] HEADER_BASE = DATA_WIDTH'(HEADER_BASE_DEFAULT)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            ena,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [DATA_WIDTH-1:0]           tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            busy
);

    localparam int               IDX_W     = $clog2(NUM_REQ);
    localparam int               CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    arb_state_t             state;
    logic [IDX_W-1:0]       gnt_idx;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       win_idx;
    logic [CNT_W-1:0]       beat_cnt;
    logic [NUM_REQ-1:0]     winner;
    logic                   found;
    logic                   g_valid;
    logic                   g_last;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  g_data;
    logic [DATA_WIDTH-1:0]  hdr_byte;

    rr_priority_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .winner (winner),
        .found  (found)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) win_idx = IDX_W'(i);
        end
    end

    assign g_valid  = req_valid[gnt_idx];
    assign g_last   = req_last[gnt_idx];
    assign g_data   = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign hdr_byte = DATA_WIDTH'(header_byte(32'(HEADER_BASE), 32'(gnt_idx)));
    assign accept   = ena && (state == DATA) && g_valid && tx_ready;
    assign busy     = (state != IDLE);

    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        case (state)
            HEADER: begin
                tx_valid = ena;
                tx_data  = hdr_byte;
            end
            DATA: begin
                tx_valid  = ena && g_valid;
                tx_data   = g_data;
                req_ready = (ena && tx_ready) ? grant : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant    <= '0;
            gnt_idx  <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= winner;
                        gnt_idx  <= win_idx;
                        beat_cnt <= '0;
                        state    <= (HEADER_EN != 0) ? HEADER : DATA;
                    end
                end
                HEADER: begin
                    if (tx_ready) state <= DATA;
                end
                DATA: begin
                    if (accept) begin
                        // Packet end or burst cap both hand the link to the next requester.
                        if (g_last || beat_cnt == LAST_BEAT) begin
                            state    <= IDLE;
                            grant    <= '0;
                            beat_cnt <= '0;
                            rr_ptr   <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
